// File: rtl/decode_seq_if.sv
// ----------------------------------------------------------------------------
// decode_seq_if
//   Handshake bundle between instruction fetch, the decode sequencer and the
//   decode/immediate datapath.
//
//   Fetch side  : if_valid, if_instr[31:0], if_pc[31:0] in; if_ready out
//   Decode side : id_valid, id_instr[31:0], id_pc[31:0], id_imm_sel[2:0],
//                 id_illegal out; id_ready in
//   Control     : flush (synchronous discard of buffered entries)
//
//   Modports: slave  = the sequencer itself
//             master = the environment (fetch + decode) around it
// ----------------------------------------------------------------------------
interface decode_seq_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [2:0]  id_imm_sel;
    logic        id_illegal;

    logic        flush;

    modport slave (
        input  if_valid, if_instr, if_pc, id_ready, flush,
        output if_ready, id_valid, id_instr, id_pc, id_imm_sel, id_illegal
    );

    modport master (
        output if_valid, if_instr, if_pc, id_ready, flush,
        input  if_ready, id_valid, id_instr, id_pc, id_imm_sel, id_illegal
    );
endinterface

// File: rtl/decode_sequencer.sv
// ----------------------------------------------------------------------------
// decode_sequencer
//   Two-entry in-order buffer between fetch and decode. Each instruction is
//   pre-decoded at push time (immediate format select + illegal flag) and
//   stored with its word and PC. Outputs come straight from the head entry
//   registers; if_ready depends only on registered state.
//
//   Ports:
//     clk        single clock, rising edge
//     rst        asynchronous, active-high reset
//     bus        decode_seq_if.slave (fetch/decode handshakes, flush)
//     stall_cnt  [CNT_W-1:0] saturating count of cycles with
//                id_valid && !id_ready (only with DECODE_SEQ_STALL_CNT_EN)
//
//   Configuration macro: DECODE_SEQ_STALL_CNT_EN
//     defined   -> parameter CNT_W and output stall_cnt exist
//     undefined -> no counter, no port; behaviour otherwise identical
//
//   imm_sel encoding: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
// ----------------------------------------------------------------------------
module decode_sequencer
`ifdef DECODE_SEQ_STALL_CNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic              clk,
    input  logic              rst,
    decode_seq_if.slave       bus
`ifdef DECODE_SEQ_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  imm_sel;
        logic        illegal;
    } entry_t;

    // Pre-decode of the major opcode; result travels with the entry.
    function automatic entry_t make_entry(input logic [31:0] instr,
                                          input logic [31:0] pc);
        entry_t e;
        e.instr   = instr;
        e.pc      = pc;
        e.imm_sel = 3'd0;
        e.illegal = 1'b0;
        unique case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: e.imm_sel = 3'd1;
            7'b0100011:                         e.imm_sel = 3'd2;
            7'b1100011:                         e.imm_sel = 3'd3;
            7'b0110111, 7'b0010111:             e.imm_sel = 3'd4;
            7'b1101111:                         e.imm_sel = 3'd5;
            7'b0110011:                         e.imm_sel = 3'd0;
            default:                            e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    state_e state_q, state_d;
    entry_t head_q,  head_d;
    entry_t tail_q,  tail_d;
    entry_t new_entry;
    logic   push;
    logic   pop;

    // ------------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        new_entry = make_entry(bus.if_instr, bus.if_pc);
        push      = bus.if_valid && (state_q != ST_FULL);
        pop       = (state_q != ST_EMPTY) && bus.id_ready;

        if (bus.flush) begin
            // Redirect wins over everything: drop both entries and any
            // same-cycle push. Stale entry data is never shown (id_valid=0).
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_d  = new_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_d  = new_entry;
                    end else if (push) begin
                        tail_d  = new_entry;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // if_ready is low here, so only a pop can happen.
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: the entry registers are reset as well as the state, because the
    // id_* outputs read them directly and must show zero during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: registered state only, no path from id_ready to if_ready
    // ------------------------------------------------------------------------
    assign bus.if_ready   = (state_q != ST_FULL);
    assign bus.id_valid   = (state_q != ST_EMPTY);
    assign bus.id_instr   = head_q.instr;
    assign bus.id_pc      = head_q.pc;
    assign bus.id_imm_sel = head_q.imm_sel;
    assign bus.id_illegal = head_q.illegal;

`ifdef DECODE_SEQ_STALL_CNT_EN
    // ------------------------------------------------------------------------
    // Stall counter: saturating, cleared only by rst, flush has no effect
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != ST_EMPTY) && !bus.id_ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_sequencer.sv
// ----------------------------------------------------------------------------
// tb_decode_sequencer
//   Self-checking bench for decode_sequencer. A queue holds the entries the
//   sequencer should be buffering; it is pushed when an accepted instruction
//   is driven and popped when the head is consumed. Every cycle the DUT head
//   and handshake outputs are compared against the queue front.
//   Define DECODE_SEQ_STALL_CNT_EN to also exercise the stall counter.
// ----------------------------------------------------------------------------
module tb_decode_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    decode_seq_if bus ();

`ifdef DECODE_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
    decode_sequencer #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );
`else
    decode_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  imm_sel;
        logic        illegal;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned stall_model = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode, written from the opcode table.
    function automatic exp_t expect_entry(input logic [31:0] instr,
                                          input logic [31:0] pc);
        exp_t e;
        logic [6:0] op;
        op        = instr[6:0];
        e.instr   = instr;
        e.pc      = pc;
        e.imm_sel = 3'd0;
        e.illegal = 1'b1;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67) begin e.imm_sel = 3'd1; e.illegal = 1'b0; end
        if (op == 7'h23)                               begin e.imm_sel = 3'd2; e.illegal = 1'b0; end
        if (op == 7'h63)                               begin e.imm_sel = 3'd3; e.illegal = 1'b0; end
        if (op == 7'h37 || op == 7'h17)                begin e.imm_sel = 3'd4; e.illegal = 1'b0; end
        if (op == 7'h6F)                               begin e.imm_sel = 3'd5; e.illegal = 1'b0; end
        if (op == 7'h33)                               begin e.imm_sel = 3'd0; e.illegal = 1'b0; end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] instr,
                         input logic [31:0] pc, input logic rdy, input logic fl);
        bus.if_valid = v;
        bus.if_instr = instr;
        bus.if_pc    = pc;
        bus.id_ready = rdy;
        bus.flush    = fl;
    endtask

    // Compare outputs (at negedge), advance one clock, update the model.
    task automatic cycle();
        bit   push, pop;
        exp_t e;
        check("id_valid", 64'(bus.id_valid), 64'(sb.size() != 0));
        check("if_ready", 64'(bus.if_ready), 64'(sb.size() < 2));
        if (sb.size() != 0) begin
            check("id_instr",   64'(bus.id_instr),   64'(sb[0].instr));
            check("id_pc",      64'(bus.id_pc),      64'(sb[0].pc));
            check("id_imm_sel", 64'(bus.id_imm_sel), 64'(sb[0].imm_sel));
            check("id_illegal", 64'(bus.id_illegal), 64'(sb[0].illegal));
        end
`ifdef DECODE_SEQ_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(stall_model));
        if (sb.size() != 0 && !bus.id_ready && stall_model != 32'hFFFF)
            stall_model++;
`endif
        push = bus.if_valid && (sb.size() < 2);
        pop  = (sb.size() != 0) && bus.id_ready;
        e    = expect_entry(bus.if_instr, bus.if_pc);
        @(posedge clk);
        if (bus.flush) begin
            sb.delete();
        end else begin
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back(e);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset, asserted away from any clock edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check("rst_id_valid",   64'(bus.id_valid),   64'd0);
        check("rst_if_ready",   64'(bus.if_ready),   64'd1);
        check("rst_id_instr",   64'(bus.id_instr),   64'd0);
        check("rst_id_pc",      64'(bus.id_pc),      64'd0);
        check("rst_id_imm_sel", 64'(bus.id_imm_sel), 64'd0);
        check("rst_id_illegal", 64'(bus.id_illegal), 64'd0);
`ifdef DECODE_SEQ_STALL_CNT_EN
        check("rst_stall_cnt",  64'(stall_cnt),      64'd0);
        stall_model = 0;
`endif
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] SW   = 32'h00112023;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] JAL  = 32'h0000006F;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] BAD  = 32'hFFFFFFFF;

    logic [31:0] pool [8] = '{ADDI, SW, BEQ, JAL, ADD, BAD, 32'h12345037, 32'h00000017};

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        async_reset();

        // addi with id_ready=1: visible next cycle, then drained
        drive(1'b1, ADDI, 32'h0, 1'b1, 1'b0); cycle();
        check("addi_imm_sel", 64'(bus.id_imm_sel), 64'd1);
        check("addi_illegal", 64'(bus.id_illegal), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); cycle();
        cycle();

        // sw then beq with id_ready=0: FULL, head held, then beq promoted
        drive(1'b1, SW,  32'h4, 1'b0, 1'b0); cycle();
        drive(1'b1, BEQ, 32'h8, 1'b0, 1'b0); cycle();
        check("full_if_ready", 64'(bus.if_ready), 64'd0);
        drive(1'b1, ADD, 32'hC, 1'b0, 1'b0); cycle();   // refused while FULL
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); cycle();
        check("held_imm_sel", 64'(bus.id_imm_sel), 64'd2);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); cycle();
        check("beq_imm_sel", 64'(bus.id_imm_sel), 64'd3);
        cycle(); cycle();

        // ONE + push(jal) + pop: stays ONE with jal at head
        drive(1'b1, ADDI, 32'h10, 1'b0, 1'b0); cycle();
        drive(1'b1, JAL,  32'h14, 1'b1, 1'b0); cycle();
        check("jal_imm_sel", 64'(bus.id_imm_sel), 64'd5);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); cycle(); cycle();

        // FULL + flush + if_valid: EMPTY next cycle
        drive(1'b1, SW,  32'h20, 1'b0, 1'b0); cycle();
        drive(1'b1, BEQ, 32'h24, 1'b0, 1'b0); cycle();
        drive(1'b1, ADD, 32'h28, 1'b1, 1'b1); cycle();
        check("flush_id_valid", 64'(bus.id_valid), 64'd0);
        check("flush_if_ready", 64'(bus.if_ready), 64'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); cycle();

        // illegal and add
        drive(1'b1, BAD, 32'h30, 1'b0, 1'b0); cycle();
        check("bad_illegal", 64'(bus.id_illegal), 64'd1);
        drive(1'b1, ADD, 32'h34, 1'b1, 1'b0); cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); cycle();
        check("add_illegal", 64'(bus.id_illegal), 64'd0);
        cycle(); cycle();

        // random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                  32'(i * 4), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0));
            cycle();
        end

        // reset mid-transfer, then first push after reset becomes head
        drive(1'b1, SW,  32'h40, 1'b0, 1'b0); cycle();
        drive(1'b1, BEQ, 32'h44, 1'b0, 1'b0); cycle();
        async_reset();
        drive(1'b1, JAL, 32'h80, 1'b0, 1'b0); cycle();
        check("post_rst_pc", 64'(bus.id_pc), 64'h80);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); cycle(); cycle();

`ifdef DECODE_SEQ_STALL_CNT_EN
        // saturate the stall counter, then reset clears it
        drive(1'b1, ADDI, 32'h90, 1'b0, 1'b0); cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) cycle();
        check("stall_sat", 64'(stall_cnt), 64'hFFFF);
        async_reset();
        check("stall_after_rst", 64'(stall_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
